// File: rtl/alu_mb_pkg.sv
// Purpose : shared types and constants for the multi-byte ALU sequencer.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: mb_op_e wide-op encoding, 8-bit ALU command codes, sequencer state
//           enum, and small decode helpers used by alu_mb_seq.
package alu_mb_pkg;

  // Wide operation requested by the control unit; 3'b111 is left unassigned
  // and reported as an illegal op.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SHL = 3'd1,
    OP_SHR = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_CMP = 3'd6
  } mb_op_e;

  // Command codes understood by the external 8-bit ALU.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_LSH = 4'b0001;
  localparam logic [3:0] ALU_RSH = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_CMP = 4'b1101;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op != 3'b111);
  endfunction

  // Ops whose carry/shift bit ripples from byte to byte and ends up in cout.
  function automatic logic op_chains(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic [3:0] alu_cmd_of(input logic [2:0] op);
    logic [3:0] cmd;
    cmd = ALU_NOP;
    case (op)
      OP_ADD:  cmd = ALU_ADD;
      OP_SHL:  cmd = ALU_LSH;
      OP_SHR:  cmd = ALU_RSH;
      OP_AND:  cmd = ALU_AND;
      OP_OR:   cmd = ALU_OR;
      OP_XOR:  cmd = ALU_XOR;
      OP_CMP:  cmd = ALU_CMP;
      default: cmd = ALU_NOP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/alu_mb_seq.sv
// Purpose : steps an external combinational 8-bit ALU one byte per cycle to run an NBYTES-wide op.
// Latency : done pulses NBYTES+1 cycles after the cycle start is presented (1 cycle for an illegal op).
// Backpr. : ready=1 only in IDLE; start outside IDLE is dropped, nothing is queued.
//
// Ports:
//   clk, reset_n               clock, async active-low reset
//   start/ready                op request handshake (accepted when both high)
//   op, opa, opb, cin          op code, wide operands, first-byte carry/shift-in
//   alu_cmd/a/b/sc             drive to the ALU for the current byte (NOP/0 outside RUN)
//   alu_rslt/sc_in/eq          ALU response for the current byte
//   result, cout, eq, err      registered wide result; valid when done pulses, held until next start
//   done                       one-cycle completion pulse
module alu_mb_seq
  import alu_mb_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  ready,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  input  logic                  cin,
  output logic [3:0]            alu_cmd,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_sc,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sc_in,
  input  logic                  alu_eq,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  eq,
  output logic                  err,
  output logic                  done
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES) + 1;

  seq_state_e         r_state;
  logic [2:0]         r_op;
  logic [W-1:0]       r_opa;
  logic [W-1:0]       r_opb;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_result;
  logic               r_cout;
  logic               r_eq;
  logic               r_err;
  logic               r_done;

  logic [IDX_W-1:0]   w_byte_sel;
  logic               w_last;
  logic [3:0]         w_cmd;
  logic [7:0]         w_a;
  logic [7:0]         w_b;
  logic               w_sc;

  // Right shifts must see the MSB byte first so the shifted-out bit can
  // enter the top of the next lower byte.
  assign w_byte_sel = (r_op == OP_SHR) ? (IDX_W'(NBYTES - 1) - r_idx) : r_idx;
  assign w_last     = (r_idx == IDX_W'(NBYTES - 1));

  // ALU drive. r_carry holds cin for byte 0 and the previous byte's sc_o
  // afterwards, so one register covers the whole chain.
  always_comb begin
    w_cmd = ALU_NOP;
    w_a   = '0;
    w_b   = '0;
    w_sc  = 1'b0;
    if (r_state == RUN) begin
      w_cmd = alu_cmd_of(r_op);
      for (int b = 0; b < NBYTES; b++) begin
        if (int'(w_byte_sel) == b) begin
          w_a = r_opa[8*b +: 8];
          w_b = r_opb[8*b +: 8];
        end
      end
      if ((r_op == OP_SHL) || (r_op == OP_SHR)) begin
        w_b = '0;
      end
      if (op_chains(r_op)) begin
        w_sc = r_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_op     <= 3'd0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_eq     <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op     <= op;
            r_opa    <= opa;
            r_opb    <= opb;
            r_carry  <= cin;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_eq     <= (op == OP_CMP);
            r_err    <= 1'b0;
            if (op_is_legal(op)) begin
              r_state <= RUN;
            end else begin
              r_state <= DONE;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_carry <= alu_sc_in;
          // CMP produces only the equality flag; its result stays cleared.
          if (r_op == OP_CMP) begin
            r_eq <= r_eq & alu_eq;
          end else begin
            for (int b = 0; b < NBYTES; b++) begin
              if (int'(w_byte_sel) == b) begin
                r_result[8*b +: 8] <= alu_rslt;
              end
            end
          end
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            if (op_chains(r_op)) begin
              r_cout <= alu_sc_in;
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready   = (r_state == IDLE);
  assign alu_cmd = w_cmd;
  assign alu_a   = w_a;
  assign alu_b   = w_b;
  assign alu_sc  = w_sc;
  assign result  = r_result;
  assign cout    = r_cout;
  assign eq      = r_eq;
  assign err     = r_err;
  assign done    = r_done;

endmodule

// File: tb/tb_alu_mb_seq.sv
// Bench for alu_mb_seq (NBYTES=2) with a behavioural 8-bit ALU attached.
// A wide-arithmetic model predicts each op; a negedge monitor checks ready,
// idle ALU drive and every done against it; directed ops also carry literals.
module tb_alu_mb_seq;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          ready;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic          cin = 1'b0;
  logic [3:0]    alu_cmd;
  logic [7:0]    alu_a, alu_b;
  logic          alu_sc;
  logic [7:0]    alu_rslt;
  logic          alu_sc_in;
  logic          alu_eq;
  logic [W-1:0]  result;
  logic          cout, eq, err, done;

  alu_mb_seq #(.NBYTES(NB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .op(op),
    .opa(opa), .opb(opb), .cin(cin), .alu_cmd(alu_cmd), .alu_a(alu_a),
    .alu_b(alu_b), .alu_sc(alu_sc), .alu_rslt(alu_rslt), .alu_sc_in(alu_sc_in),
    .alu_eq(alu_eq), .result(result), .cout(cout), .eq(eq), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU.
  always_comb begin
    alu_rslt  = '0;
    alu_sc_in = 1'b0;
    alu_eq    = (alu_a == alu_b);
    case (alu_cmd)
      4'b0000: {alu_sc_in, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc};
      4'b0001: {alu_sc_in, alu_rslt} = {alu_a, alu_sc};
      4'b0010: begin alu_rslt = {alu_sc, alu_a[7:1]}; alu_sc_in = alu_a[0]; end
      4'b0100: alu_rslt = alu_a | alu_b;
      4'b0101: alu_rslt = alu_a ^ alu_b;
      4'b0110: alu_rslt = alu_a & alu_b;
      4'b1101: alu_rslt = alu_a - alu_b;
      default: ;
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         e;
    logic         er;
    int           lat;
    int           scyc;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   s_cyc = -100;
  int   s_lat = 0;
  int   done_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Whole-word model of the wide op, straight from the op definitions.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci);
    exp_t   m;
    logic [W:0] s;
    m.res = '0; m.co = 1'b0; m.e = 1'b0; m.er = 1'b0; m.lat = NB + 1; m.scyc = 0;
    case (o)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci}; m.res = s[W-1:0]; m.co = s[W]; end
      3'd1: begin m.res = {a[W-2:0], ci}; m.co = a[W-1]; end
      3'd2: begin m.res = {ci, a[W-1:1]}; m.co = a[0]; end
      3'd3: m.res = a & b;
      3'd4: m.res = a | b;
      3'd5: m.res = a ^ b;
      3'd6: m.e = (a == b);
      default: begin m.er = 1'b1; m.lat = 1; end
    endcase
    return m;
  endfunction

  // Per-cycle compare process.
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      chk("ready", {31'd0, ready}, {31'd0, !((cyc > s_cyc) && (cyc <= s_cyc + s_lat))});
      if (ready) chk("idle_alu_drive", {11'd0, alu_cmd, alu_a, alu_b, alu_sc}, {11'd0, 4'hF, 17'd0});
      if (done) begin
        done_cnt++;
        if (expq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("model_result", {16'd0, result}, {16'd0, e.res});
          chk("model_flags", {29'd0, cout, eq, err}, {29'd0, e.co, e.e, e.er});
          chk("latency", 32'(cyc - e.scyc), 32'(e.lat));
        end
      end
    end
  end

  // Present start for hold_cyc cycles, then wait for done and check literals.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci, input int hold_cyc,
                        input logic [W-1:0] x_res, input logic x_co, input logic x_eq,
                        input logic x_err);
    exp_t e;
    int   d0;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    if (!ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
    d0 = done_cnt;
    e = model(o, a, b, ci);
    e.scyc = cyc;
    s_cyc = cyc;
    s_lat = e.lat;
    expq.push_back(e);
    op = o; opa = a; opb = b; cin = ci; start = 1'b1;
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      // Scramble inputs while start stays high; they must not be sampled.
      op = 3'd5; opa = ~a; opb = ~b; cin = ~ci;
    end
    start = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done_cnt != d0) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    if (!got) begin
      chk({nm, "_done_timeout"}, 32'd0, 32'd1);
      expq.delete();
    end else begin
      @(negedge clk); #1;
      chk({nm, "_result"}, {16'd0, result}, {16'd0, x_res});
      chk({nm, "_flags"}, {29'd0, cout, eq, err}, {29'd0, x_co, x_eq, x_err});
    end
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {11'd0, ready, result, cout, eq, err, done},
        {11'd0, 1'b1, 16'h0000, 4'b0000});
    chk("reset_alu_drive", {11'd0, alu_cmd, alu_a, alu_b, alu_sc}, {11'd0, 4'hF, 17'd0});
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    run_op("add_carry_byte", 3'd0, 16'h00FF, 16'h0001, 1'b0, 1, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",       3'd0, 16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("shl",            3'd1, 16'h8001, 16'hFFFF, 1'b0, 1, 16'h0002, 1'b1, 1'b0, 1'b0);
    run_op("shr_msb_first",  3'd2, 16'h8001, 16'h0000, 1'b1, 1, 16'hC000, 1'b1, 1'b0, 1'b0);
    run_op("cmp_ne",         3'd6, 16'h1234, 16'h1235, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op("cmp_eq",         3'd6, 16'h1234, 16'h1234, 1'b1, 1, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("add_cin",        3'd0, 16'h1234, 16'h4321, 1'b1, 1, 16'h5556, 1'b0, 1'b0, 1'b0);
    run_op("shl_cin",        3'd1, 16'h4000, 16'hFFFF, 1'b1, 1, 16'h8001, 1'b0, 1'b0, 1'b0);
    run_op("and",            3'd3, 16'hF0F0, 16'h3C3C, 1'b1, 1, 16'h3030, 1'b0, 1'b0, 1'b0);
    run_op("or",             3'd4, 16'hF0F0, 16'h0F0F, 1'b1, 1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("xor",            3'd5, 16'hA5A5, 16'hFFFF, 1'b0, 1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    run_op("illegal",        3'd7, 16'hFFFF, 16'hFFFF, 1'b1, 1, 16'h0000, 1'b0, 1'b0, 1'b1);

    // start held through RUN and DONE: exactly one done, first operands used.
    d0 = done_cnt;
    run_op("start_held",     3'd0, 16'h0F0F, 16'h0101, 1'b0, 4, 16'h1010, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("start_held_single_done", 32'(done_cnt - d0), 32'd1);

    // Reset during the second RUN cycle aborts the op with no done.
    d0 = done_cnt;
    op = 3'd0; opa = 16'h7777; opb = 16'h1111; cin = 1'b1; start = 1'b1;
    s_cyc = cyc; s_lat = NB + 1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    s_cyc = -100;
    expq.delete();
    #1;
    chk("abort_outputs", {11'd0, ready, result, cout, eq, err, done},
        {11'd0, 1'b1, 16'h0000, 4'b0000});
    @(negedge clk);
    #1;
    chk("abort_ready_next", {31'd0, ready}, 32'd1);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    run_op("after_abort",    3'd0, 16'h7777, 16'h1111, 1'b1, 1, 16'h8889, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
